// File: rtl/matrix_pkg.sv
// Shared constants, error codes and parser state encoding for the UART matrix loader.
package matrix_pkg;
  localparam int         MAX_DIM     = 5;
  localparam logic [7:0] FRAME_HDR   = 8'hA5;
  localparam logic [1:0] ERR_FRAME   = 2'd0;
  localparam logic [1:0] ERR_DIM     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {P_IDLE, P_ROWS, P_COLS, P_DATA, P_CHK} parser_state_t;

  function automatic logic dim_ok(input logic [7:0] d, input int max_dim);
    return (d != 8'd0) && (int'(d) <= max_dim);
  endfunction
endpackage

// File: rtl/uart_matrix_loader_if.sv
// Matrix store write port plus load status toward the controller.
interface uart_matrix_loader_if;
  logic       mat_we;
  logic [4:0] mat_waddr;
  logic [7:0] mat_wdata;
  logic [2:0] mat_rows;
  logic [2:0] mat_cols;
  logic       load_done;
  logic       load_err;
  logic [1:0] err_code;
  logic       busy;

  modport master (output mat_we, mat_waddr, mat_wdata, mat_rows, mat_cols,
                         load_done, load_err, err_code, busy);
  modport slave  (input  mat_we, mat_waddr, mat_wdata, mat_rows, mat_cols,
                         load_done, load_err, err_code, busy);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, stop-bit check.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     state;
  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= R_IDLE;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_d       <= rx_s2;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        R_IDLE: if (rx_d && !rx_s2) begin
          state <= R_START;
          cnt   <= '0;
        end
        // a start bit that is high again at half-bit was a glitch
        R_START: if (cnt == HALF) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rx_s2 ? R_IDLE : R_DATA;
        end else cnt <= cnt + 1'b1;
        R_DATA: if (cnt == FULL) begin
          cnt     <= '0;
          shreg   <= {rx_s2, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= R_STOP;
        end else cnt <= cnt + 1'b1;
        R_STOP: if (cnt == FULL) begin
          cnt   <= '0;
          state <= R_IDLE;
          if (rx_s2) begin
            byte_valid <= 1'b1;
            byte_data  <= shreg;
          end else frame_err <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_matrix_loader.sv
// Parses A5/rows/cols/elements/checksum frames from the UART into row-major matrix writes.
module uart_matrix_loader #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int MAX_DIM     = matrix_pkg::MAX_DIM,
  parameter int ELEM_W      = 8,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  input  logic enable,
  uart_matrix_loader_if.master mat
);
  import matrix_pkg::*;

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TW           = $clog2(TIMEOUT_CYC + 1);

  logic              byte_valid, frame_err;
  logic [7:0]        byte_data;
  parser_state_t     state;
  logic [2:0]        rows_l, cols_l;
  logic [4:0]        count, idx;
  logic [ELEM_W-1:0] chk;
  logic [TW-1:0]     gap_cnt;
  logic              timeout;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign timeout  = (state != P_IDLE) && (gap_cnt == TW'(TIMEOUT_CYC - 1));
  assign mat.busy = (state != P_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= P_IDLE;
      rows_l        <= '0;
      cols_l        <= '0;
      count         <= '0;
      idx           <= '0;
      chk           <= '0;
      gap_cnt       <= '0;
      mat.mat_we    <= 1'b0;
      mat.mat_waddr <= '0;
      mat.mat_wdata <= '0;
      mat.mat_rows  <= '0;
      mat.mat_cols  <= '0;
      mat.load_done <= 1'b0;
      mat.load_err  <= 1'b0;
      mat.err_code  <= '0;
    end else begin
      mat.mat_we    <= 1'b0;
      mat.load_done <= 1'b0;
      mat.load_err  <= 1'b0;
      gap_cnt       <= (byte_valid || state == P_IDLE) ? '0 : gap_cnt + 1'b1;
      // abort sources in priority order, ahead of normal byte handling
      if (!enable) begin
        state <= P_IDLE;
      end else if (frame_err && state != P_IDLE) begin
        state        <= P_IDLE;
        mat.load_err <= 1'b1;
        mat.err_code <= ERR_FRAME;
      end else if (timeout) begin
        state        <= P_IDLE;
        mat.load_err <= 1'b1;
        mat.err_code <= ERR_TIMEOUT;
      end else if (byte_valid) begin
        case (state)
          P_IDLE: if (byte_data == FRAME_HDR) state <= P_ROWS;
          P_ROWS: if (!dim_ok(byte_data, MAX_DIM)) begin
            state        <= P_IDLE;
            mat.load_err <= 1'b1;
            mat.err_code <= ERR_DIM;
          end else begin
            rows_l <= byte_data[2:0];
            chk    <= byte_data;
            state  <= P_COLS;
          end
          P_COLS: if (!dim_ok(byte_data, MAX_DIM)) begin
            state        <= P_IDLE;
            mat.load_err <= 1'b1;
            mat.err_code <= ERR_DIM;
          end else begin
            cols_l <= byte_data[2:0];
            count  <= {2'b00, rows_l} * {2'b00, byte_data[2:0]};
            idx    <= '0;
            chk    <= chk ^ byte_data;
            state  <= P_DATA;
          end
          P_DATA: begin
            mat.mat_we    <= 1'b1;
            mat.mat_waddr <= idx;
            mat.mat_wdata <= byte_data;
            chk           <= chk ^ byte_data;
            idx           <= idx + 5'd1;
            if (idx == count - 5'd1) state <= P_CHK;
          end
          P_CHK: begin
            state <= P_IDLE;
            if (byte_data == chk) begin
              mat.mat_rows  <= rows_l;
              mat.mat_cols  <= cols_l;
              mat.load_done <= 1'b1;
            end else begin
              mat.load_err <= 1'b1;
              mat.err_code <= ERR_CHK;
            end
          end
          default: state <= P_IDLE;
        endcase
      end
    end
  end
endmodule
